// File: rtl/sensor_timer_pkg.sv
// Shared types and constants for the sensor_timer block (S1->S2 interval timer).
package sensor_timer_pkg;

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam int unsigned TIME_W   = 19;
    localparam int unsigned MS_PER_S = 1000;

endpackage

// File: rtl/sensor_timer_sensor_conditioner.sv
// Per-sensor front end: 2-flop synchronizer, debounce filter (SENSOR_TIMER_DEBOUNCE_EN),
// and a registered rising-edge detector producing a one-cycle pulse.
module sensor_conditioner #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

`ifdef SENSOR_TIMER_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] stable_cnt;
    logic             filt;

    // Count cycles the synchronized value has differed from the filtered level;
    // any return to the filtered level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt       <= 1'b0;
            stable_cnt <= '0;
        end else if (sync == filt) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            filt       <= sync;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    // DEB_CYCLES has no role without the filter.
    logic unused_deb;
    assign unused_deb = |DEB_CYCLES;
    assign level      = sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_d <= level;
            rise    <= level & ~level_d;
        end
    end

endmodule

// File: rtl/sensor_timer.sv
// Millisecond interval timer between S1 and S2 rising edges; never reports zero.
// Sensor debounce is enabled by defining SENSOR_TIMER_DEBOUNCE_EN.
module sensor_timer #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TIME_W     = sensor_timer_pkg::TIME_W,
    parameter int unsigned TIMEOUT_MS = 500_000,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s1_in,
    input  logic              s2_in,
    output logic [TIME_W-1:0] time_out,
    output logic              time_valid,
    output logic              timeout,
    output logic              busy
);

    import sensor_timer_pkg::*;

    localparam int unsigned TICK_DIV = CLK_HZ / MS_PER_S;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] MS_LIMIT = TIME_W'(TIMEOUT_MS);

    logic e1;
    logic e2;
    logic unused_s1_level;
    logic unused_s2_level;

    sensor_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (s1_in),
        .level (unused_s1_level),
        .rise  (e1)
    );

    sensor_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_s2 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (s2_in),
        .level (unused_s2_level),
        .rise  (e2)
    );

    state_t            state;
    state_t            state_n;
    logic [PRE_W-1:0]  pre;
    logic [PRE_W-1:0]  pre_n;
    logic [TIME_W-1:0] ms_count;
    logic [TIME_W-1:0] ms_n;
    logic [TIME_W-1:0] ms_now;
    logic [TIME_W-1:0] time_out_n;
    logic              valid_n;
    logic              timeout_n;
    logic              tick;

    always_comb begin
        state_n    = state;
        pre_n      = pre;
        ms_n       = ms_count;
        time_out_n = time_out;
        valid_n    = 1'b0;
        timeout_n  = 1'b0;
        tick       = (pre == PRE_LAST);
        // ms_now includes a tick landing on this edge, so the reported value
        // is the whole ms elapsed from MEASURE entry up to the deciding edge.
        ms_now     = (tick && (ms_count != MS_LIMIT)) ? ms_count + 1'b1 : ms_count;

        unique case (state)
            IDLE: begin
                if (e1) begin
                    pre_n   = '0;
                    ms_n    = '0;
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                pre_n = tick ? '0 : pre + 1'b1;
                ms_n  = ms_now;
                if (e2) begin
                    time_out_n = (ms_now == '0) ? TIME_W'(1) : ms_now;
                    valid_n    = 1'b1;
                    state_n    = IDLE;
                end else if (ms_now == MS_LIMIT) begin
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pre        <= '0;
            ms_count   <= '0;
            time_out   <= '0;
            time_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            pre        <= pre_n;
            ms_count   <= ms_n;
            time_out   <= time_out_n;
            time_valid <= valid_n;
            timeout    <= timeout_n;
        end
    end

    assign busy = (state == MEASURE);

endmodule

// File: tb/tb_sensor_timer.sv
// Scoreboard bench for sensor_timer; adapts expected latency to SENSOR_TIMER_DEBOUNCE_EN.
module tb_sensor_timer;

    localparam int TW    = 19;
    localparam int TICK  = 4;
    localparam int TO_MS = 20;
    localparam int DEB   = 3;
    localparam int LIMIT = TO_MS * TICK;
`ifdef SENSOR_TIMER_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
    localparam int LAT    = 2 + DEB + 1 + 1;
`else
    localparam bit DEB_ON = 1'b0;
    localparam int LAT    = 4;
`endif

    logic          clk;
    logic          rst_n;
    logic          s1_in;
    logic          s2_in;
    logic [TW-1:0] time_out;
    logic          time_valid;
    logic          timeout;
    logic          busy;

    sensor_timer #(
        .CLK_HZ     (4000),
        .TIME_W     (TW),
        .TIMEOUT_MS (TO_MS),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s1_in      (s1_in),
        .s2_in      (s2_in),
        .time_out   (time_out),
        .time_valid (time_valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int last_val = 0;
    int run_len = 0;
    int last_run = 0;
    bit exp_kind[$];
    int exp_val[$];

    // Monitor: every output pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && (time_valid || timeout)) begin
            checks++;
            if (exp_kind.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b timeout=%0b time_out=%0d, required no pulse",
                         time_valid, timeout, time_out);
            end else begin
                bit k;
                int v;
                k = exp_kind.pop_front();
                v = exp_val.pop_front();
                if (time_valid !== !k || timeout !== k || busy !== 1'b0 || time_out !== TW'(v)) begin
                    errors++;
                    $display("FAIL event: valid=%0b timeout=%0b busy=%0b time_out=%0d, required valid=%0b timeout=%0b busy=0 time_out=%0d",
                             time_valid, timeout, busy, time_out, !k, k, v);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) run_len = 0;
        else if (busy) run_len++;
        else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference rule: elapsed cycles E between raw S1 and S2 rises.
    task automatic expect_meas(input int e);
        if (e >= 1 && e <= LIMIT) begin
            last_val = (e / TICK == 0) ? 1 : e / TICK;
            exp_kind.push_back(1'b0);
            exp_val.push_back(last_val);
        end else begin
            exp_kind.push_back(1'b1);
            exp_val.push_back(last_val);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (!busy) done = 1'b1;
            else step(1);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait: busy=1 after 300 cycles, required 0", name);
        end
    endtask

    task automatic finish_txn(input int e, input string name);
        int dur;
        dur = (e >= 1 && e <= LIMIT) ? e : LIMIT;
        step(LAT + 2);
        wait_idle(name);
        step(1);
        check({name, "_busy_cycles"}, last_run, dur);
        s1_in = 1'b0;
        s2_in = 1'b0;
        step(LAT + 6);
    endtask

    task automatic run_txn(input int e, input string name);
        last_run = 0;
        expect_meas(e);
        s1_in = 1'b1;
        if (e == 0) s2_in = 1'b1;
        else begin
            step(e);
            s2_in = 1'b1;
        end
        finish_txn(e, name);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        bit seen;
        rst_n = 1'b0;
        s1_in = 1'b1;
        s2_in = 1'b1;
        step(5);
        check("rst_time_out", int'(time_out), 0);
        check("rst_time_valid", int'(time_valid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_busy", int'(busy), 0);

        // Both sensors high out of reset: edges coincide, so S2 is ignored and it times out.
        last_run = 0;
        expect_meas(0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(posedge clk);
            #1;
            if (busy) n = i;
        end
        check("busy_rise_latency", n, LAT);
        finish_txn(0, "reset_both_high");

        run_txn(40, "nominal");

        // Orphan S2 in IDLE.
        s2_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < LAT + 20; i++) begin
            step(1);
            if (busy) seen = 1'b1;
        end
        check("orphan_s2_busy", int'(seen), 0);
        s2_in = 1'b0;
        step(LAT + 6);

        run_txn(LIMIT + 10, "timeout");
        check("timeout_hold", int'(time_out), 10);

        // Two-cycle S2 glitch during MEASURE, clean rise later.
        last_run = 0;
        expect_meas(DEB_ON ? 32 : 12);
        s1_in = 1'b1;
        step(12);
        s2_in = 1'b1;
        step(2);
        s2_in = 1'b0;
        step(18);
        s2_in = 1'b1;
        finish_txn(DEB_ON ? 32 : 12, "glitch");

        run_txn(1, "zero_guard");
        run_txn(3, "sub_ms");
        run_txn(LIMIT, "e2_wins_at_limit");
        run_txn(LIMIT + 1, "just_past_limit");

        // Reset in the middle of a measurement.
        s1_in = 1'b1;
        step(LAT + 10);
        check("mid_busy_before_reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy_in_reset", int'(busy), 0);
        check("mid_time_out_in_reset", int'(time_out), 0);
        s1_in = 1'b0;
        last_val = 0;
        step(3);
        @(negedge clk);
        rst_n = 1'b1;
        step(LAT + 10);
        check("mid_busy_after_reset", int'(busy), 0);

        for (int t = 0; t < 12; t++) begin
            run_txn(int'($urandom_range(0, LIMIT + 10)), "random");
        end

        check("scoreboard_drained", exp_kind.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
